// File: rtl/im_loader_pkg.sv
//------------------------------------------------------------------------------
// Module  : im_loader_pkg
// Brief   : Shared state encoding and framing constants for the IM loader.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package im_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_HI = 4'd1,
    LEN_LO = 4'd2,
    DATA   = 4'd3,
    WRITE  = 4'd4,
    CHK    = 4'd5,
    DONE   = 4'd6,
    ERR    = 4'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/im_loader_word_asm.sv
//------------------------------------------------------------------------------
// Module  : word_asm
// Brief   : Big-endian byte-to-word shift register with byte counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module word_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_last_byte
);

  localparam logic [1:0] c_last_cnt = 2'(BYTES_PER_WORD - 1);

  logic [23:0] r_word;
  logic [1:0]  r_cnt;

  // Only the three older bytes need storing; the fourth arrives live.
  assign o_word_next = {r_word, i_byte};
  assign o_last_byte = (r_cnt == c_last_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_next[23:0];
      r_cnt  <= r_cnt + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
//------------------------------------------------------------------------------
// Module  : im_loader
// Brief   : Boot loader: byte stream -> IM write port, holds CPU until done.
//           Optional trailing checksum byte: define IM_LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module im_loader
  import im_loader_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [31:0]       instru_w,
  output logic              instru_en,
  output logic [ADDR_W-1:0] address,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int c_len_w = 8 * LEN_BYTES;

  state_t             r_state;
  logic [7:0]         r_len_hi;
  logic [c_len_w-1:0] r_len;
  logic [6:0]         r_word_idx;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]         r_sum;
`endif

  logic               w_accept;
  logic               w_restart;
  logic               w_last_word;
  logic [c_len_w-1:0] w_len;
  logic [31:0]        w_word_next;
  logic               w_last_byte;

  assign w_accept    = byte_valid & byte_ready;
  assign w_restart   = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_len       = {r_len_hi, byte_data};
  assign w_last_word = (c_len_w'(r_word_idx) + c_len_w'(1)) == r_len;

  word_asm u_word_asm (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_restart),
    .i_shift     (w_accept && (r_state == DATA)),
    .i_byte      (byte_data),
    .o_word_next (w_word_next),
    .o_last_byte (w_last_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
      byte_ready <= 1'b0;
      instru_w   <= '0;
      instru_en  <= 1'b0;
      address    <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      instru_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= LEN_HI;
            r_word_idx <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end
        LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= byte_data;
            r_state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len == '0) begin
`ifdef IM_LOADER_CHECKSUM_EN
              r_state    <= CHK;
`else
              r_state    <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end else if (w_len > c_len_w'(MAX_WORDS)) begin
              r_state    <= ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + byte_data;
`endif
            // Write strobe is registered: it appears the cycle after the 4th byte.
            if (w_last_byte) begin
              r_state    <= WRITE;
              byte_ready <= 1'b0;
              instru_en  <= 1'b1;
              instru_w   <= w_word_next;
              address    <= ADDR_W'({r_word_idx, 2'b00});
            end
          end
        end
        WRITE: begin
          r_word_idx <= r_word_idx + 7'd1;
          if (w_last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
            r_state    <= CHK;
            byte_ready <= 1'b1;
`else
            r_state    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
`endif
          end else begin
            r_state    <= DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_data == r_sum) begin
              r_state  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state  <= ERR;
              err      <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
